// File: rtl/instr_encoder_loader.sv
// RISC-V instruction encoder and instruction-memory preload port.
// Packs R/lw/sw/beq words and writes them to consecutive word addresses.
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        op_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic              full,
    output logic [CW-1:0]     count
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic [CW-1:0]     count_q, count_d;

    logic [31:0]       enc;
    logic              accept;
    logic              bad_branch;

    assign req_ready  = !full_q && !clear && !rst;
    assign accept     = req_valid && req_ready;
    assign bad_branch = (op_class == 2'b11) && imm[0];

    // Assemble the instruction word for the selected op class.
    always_comb begin
        enc = '0;
        unique case (op_class)
            2'b00: enc = {funct7, rs2, rs1, funct3, rd, OP_R};
            2'b01: enc = {imm[11:0], rs1, funct3, rd, OP_LW};
            2'b10: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_SW};
            2'b11: enc = {imm[12], imm[10:5], rs2, rs1, funct3,
                          imm[4:1], imm[11], OP_BEQ};
        endcase
    end

    // Next-state: clear restarts the load, misaligned branches only flag err.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (accept && bad_branch) begin
            err_d = 1'b1;
        end else if (accept) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(BASE_ADDR) + (ADDR_W'(count_q) << 2);
            wdata_d = enc;
            count_d = count_q + CW'(1);
        end
        full_d = (count_d == CW'(DEPTH));
    end

    // State registers; reset also drops any write still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            full_q  <= full_d;
            count_q <= count_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign full       = full_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with DEPTH=4.
// Hand-computed instruction words and addresses.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        op_class;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [12:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              err;
    logic              full;
    logic [CW-1:0]     count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    instr_encoder_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .op_class(op_class),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .funct3(funct3),
        .funct7(funct7),
        .imm(imm),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .err(err),
        .full(full),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [12:0] im);
        req_valid = 1'b1;
        op_class  = op;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        funct3    = f3;
        funct7    = f7;
        imm       = im;
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        req_valid = 1'b0;
        op_class = '0;
        rd = '0;
        rs1 = '0;
        rs2 = '0;
        funct3 = '0;
        funct7 = '0;
        imm = '0;
        tick();
        tick();
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_err", 32'(err), 0);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(req_ready), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 1);

        // add x3,x1,x2
        set_req(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
        tick();
        req_valid = 1'b0;
        check("add_we", 32'(imem_we), 1);
        check("add_addr", 32'(imem_addr), 32'h000);
        check("add_wdata", imem_wdata, 32'h002081B3);
        check("add_count", 32'(count), 1);
        tick();
        check("idle_we", 32'(imem_we), 0);
        check("hold_wdata", imem_wdata, 32'h002081B3);
        check("hold_addr", 32'(imem_addr), 32'h000);

        clear = 1'b1;
        #1;
        check("clear_ready", 32'(req_ready), 0);
        tick();
        clear = 1'b0;
        check("clear_count", 32'(count), 0);

        // lw x5,8(x2) then sw x5,12(x2) back-to-back
        set_req(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8);
        tick();
        check("lw_we", 32'(imem_we), 1);
        check("lw_addr", 32'(imem_addr), 32'h000);
        check("lw_wdata", imem_wdata, 32'h00812283);
        set_req(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12);
        tick();
        check("sw_we", 32'(imem_we), 1);
        check("sw_addr", 32'(imem_addr), 32'h004);
        check("sw_wdata", imem_wdata, 32'h00512623);
        check("sw_count", 32'(count), 2);

        // beq x1,x2,-8
        set_req(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
        tick();
        req_valid = 1'b0;
        check("beq_addr", 32'(imem_addr), 32'h008);
        check("beq_wdata", imem_wdata, 32'hFE208CE3);
        check("beq_count", 32'(count), 3);

        // misaligned branch
        set_req(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0005);
        tick();
        req_valid = 1'b0;
        check("bad_err", 32'(err), 1);
        check("bad_we", 32'(imem_we), 0);
        check("bad_count", 32'(count), 3);
        tick();
        check("bad_err_pulse", 32'(err), 0);

        // fourth word fills the program
        set_req(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
        tick();
        check("fill_we", 32'(imem_we), 1);
        check("fill_addr", 32'(imem_addr), 32'h00C);
        check("fill_count", 32'(count), 4);
        check("fill_full", 32'(full), 1);
        check("fill_ready", 32'(req_ready), 0);
        tick();
        check("full_hold_we", 32'(imem_we), 0);
        tick();
        check("full_hold_we2", 32'(imem_we), 0);
        check("full_hold_cnt", 32'(count), 4);

        // clear wins over held req_valid
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_we", 32'(imem_we), 0);
        check("clr_full", 32'(full), 0);
        check("clr_count", 32'(count), 0);
        set_req(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8);
        tick();
        req_valid = 1'b0;
        clear = 1'b1;
        check("post_clr_we", 32'(imem_we), 1);
        check("post_clr_addr", 32'(imem_addr), 32'h000);
        check("post_clr_wdata", imem_wdata, 32'h00812283);
        tick();
        clear = 1'b0;
        check("clr2_count", 32'(count), 0);

        // reset mid-stream drops the in-flight write
        set_req(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12);
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_we", 32'(imem_we), 0);
        check("mid_rst_addr", 32'(imem_addr), 0);
        check("mid_rst_wdata", imem_wdata, 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_err", 32'(err), 0);
        rst = 1'b0;
        set_req(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
        tick();
        req_valid = 1'b0;
        check("rel_we", 32'(imem_we), 1);
        check("rel_addr", 32'(imem_addr), 32'h000);
        check("rel_wdata", imem_wdata, 32'hFE208CE3);
        check("rel_count", 32'(count), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
